// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the N x N systolic GEMM array: skewed operand feed, then partial-sum drain. done is k_len+2N cycles after start is accepted.
// hold is sampled at each edge. While hold is high the next step is presented with its enables low, and the step is repeated once hold drops.
module systolic_seq_ctrl #(
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic                 pe_en,
    output logic [KW:0]          feed_cnt,
    output logic [N-1:0]         lane_valid,
    output logic                 res_valid,
    output logic [$clog2(N)-1:0] res_row
);

    localparam int CW = KW + 1;
    localparam int RW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   feed_q, feed_d;
    logic [RW-1:0]   row_q, row_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pe_en_q, pe_en_d;
    logic [N-1:0]    lane_q, lane_d;
    logic            res_valid_q, res_valid_d;
    logic            act_d;
    logic [CW-1:0]   last_feed;

    assign last_feed = {1'b0, k_q} + CW'(N - 2);

    // pe_en_q marks that the presented step really executed. A stalled step is not advanced past.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        feed_d  = feed_q;
        row_d   = row_q;
        act_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d    = k_len;
                    feed_d = '0;
                    row_d  = '0;
                    if (k_len != '0) begin
                        state_d = FEED;
                        act_d   = !hold;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            FEED: begin
                if (pe_en_q) begin
                    if (feed_q == last_feed) begin
                        state_d = DRAIN;
                        row_d   = '0;
                    end else begin
                        feed_d = feed_q + 1'b1;
                    end
                end
                act_d = !hold;
            end
            DRAIN: begin
                if (pe_en_q && (row_q == RW'(N - 1))) begin
                    state_d = DONE;
                end else begin
                    if (pe_en_q) begin
                        row_d = row_q + 1'b1;
                    end
                    act_d = !hold;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        pe_en_d     = act_d;
        res_valid_d = act_d && (state_d == DRAIN);
        lane_d      = '0;
        for (int i = 0; i < N; i++) begin
            lane_d[i] = act_d && (state_d == FEED) && (feed_d >= CW'(i))
                        && ((feed_d - CW'(i)) < {1'b0, k_d});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            feed_q      <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pe_en_q     <= 1'b0;
            lane_q      <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            feed_q      <= feed_d;
            row_q       <= row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pe_en_q     <= pe_en_d;
            lane_q      <= lane_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pe_en      = pe_en_q;
    assign feed_cnt   = feed_q;
    assign lane_valid = lane_q;
    assign res_valid  = res_valid_q;
    assign res_row    = row_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed vector bench for systolic_seq_ctrl (N=4, KW=8): stall, zero-length, long-job and reset-abort cases.
module tb_systolic_seq_ctrl;

    localparam int N  = 4;
    localparam int KW = 8;
    localparam int RW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          hold;
    logic          busy, done, pe_en, res_valid;
    logic [KW:0]   feed_cnt;
    logic [N-1:0]  lane_valid;
    logic [RW-1:0] res_row;

    int checks = 0;
    int errors = 0;

    systolic_seq_ctrl #(.N(N), .KW(KW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len), .hold(hold),
        .busy(busy), .done(done), .pe_en(pe_en), .feed_cnt(feed_cnt),
        .lane_valid(lane_valid), .res_valid(res_valid), .res_row(res_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st;
        logic [KW-1:0] k;
        logic          h;
        logic          busy, done, pe;
        logic [N-1:0]  lane;
        logic          rv;
        logic [RW-1:0] row;
        logic [KW:0]   cnt;
        logic          cc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, int k, logic h, logic b, logic d, logic pe,
                                logic [N-1:0] ln, logic rv, int row, int cnt, logic cc);
        vec_t v;
        v.st = st; v.k = KW'(k); v.h = h; v.busy = b; v.done = d; v.pe = pe;
        v.lane = ln; v.rv = rv; v.row = RW'(row); v.cnt = (KW+1)'(cnt); v.cc = cc;
        return v;
    endfunction

    // The inputs of a vector are sampled at the next edge. The expected values are the outputs after that edge.
    function automatic vec_t F(int cnt, logic [N-1:0] ln, logic st = 1'b0, int k = 0);
        return mk(st, k, 1'b0, 1'b1, 1'b0, 1'b1, ln, 1'b0, 0, cnt, 1'b1);
    endfunction
    function automatic vec_t S(int cnt);
        return mk(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 0, cnt, 1'b1);
    endfunction
    function automatic vec_t Dr(int row, int cnt, logic st = 1'b0, int k = 0);
        return mk(st, k, 1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b1, row, cnt, 1'b1);
    endfunction
    function automatic vec_t Dn(logic st = 1'b0, int k = 0);
        return mk(st, k, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 0, 0, 1'b0);
    endfunction
    function automatic vec_t Id(logic st = 1'b0, int k = 0);
        return mk(st, k, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 0, 0, 1'b0);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    initial begin
        int dc, da, mx, last3;

        // Job k=3: no stall
        tbl.push_back(F(0, 4'b0001, 1'b1, 3));
        tbl.push_back(F(1, 4'b0011)); tbl.push_back(F(2, 4'b0111));
        tbl.push_back(F(3, 4'b1110)); tbl.push_back(F(4, 4'b1100));
        tbl.push_back(F(5, 4'b1000));
        tbl.push_back(Dr(0, 5)); tbl.push_back(Dr(1, 5));
        tbl.push_back(Dr(2, 5)); tbl.push_back(Dr(3, 5));
        tbl.push_back(Dn()); tbl.push_back(Id());
        // Job k=3: two-cycle hold at feed_cnt=2
        tbl.push_back(F(0, 4'b0001, 1'b1, 3));
        tbl.push_back(F(1, 4'b0011));
        tbl.push_back(S(2)); tbl.push_back(S(2));
        tbl.push_back(F(2, 4'b0111)); tbl.push_back(F(3, 4'b1110));
        tbl.push_back(F(4, 4'b1100)); tbl.push_back(F(5, 4'b1000));
        tbl.push_back(Dr(0, 5)); tbl.push_back(Dr(1, 5));
        tbl.push_back(Dr(2, 5)); tbl.push_back(Dr(3, 5));
        tbl.push_back(Dn()); tbl.push_back(Id());
        // Job k=0
        tbl.push_back(Dn(1'b1, 0)); tbl.push_back(Id());
        // Job k=1: start pulsed during FEED and during DONE, then k=2 from the first IDLE cycle
        tbl.push_back(F(0, 4'b0001, 1'b1, 1));
        tbl.push_back(F(1, 4'b0010, 1'b1, 5)); tbl.push_back(F(2, 4'b0100, 1'b1, 5));
        tbl.push_back(F(3, 4'b1000));
        tbl.push_back(Dr(0, 3)); tbl.push_back(Dr(1, 3));
        tbl.push_back(Dr(2, 3)); tbl.push_back(Dr(3, 3));
        tbl.push_back(Dn());
        tbl.push_back(Id(1'b1, 4));
        tbl.push_back(F(0, 4'b0001, 1'b1, 2));
        tbl.push_back(F(1, 4'b0011)); tbl.push_back(F(2, 4'b0110));
        tbl.push_back(F(3, 4'b1100)); tbl.push_back(F(4, 4'b1000));
        tbl.push_back(Dr(0, 4)); tbl.push_back(Dr(1, 4));
        tbl.push_back(Dr(2, 4)); tbl.push_back(Dr(3, 4));
        tbl.push_back(Dn()); tbl.push_back(Id());

        reset_n = 1'b0; start = 1'b0; hold = 1'b0; k_len = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 0, busy, 0);
        chk("rst_done", 0, done, 0);
        chk("rst_pe_en", 0, pe_en, 0);
        chk("rst_lane", 0, lane_valid, 0);
        chk("rst_res_valid", 0, res_valid, 0);
        chk("rst_res_row", 0, res_row, 0);
        chk("rst_feed_cnt", 0, feed_cnt, 0);
        reset_n = 1'b1;

        for (int j = 0; j < tbl.size(); j++) begin
            start = tbl[j].st; k_len = tbl[j].k; hold = tbl[j].h;
            @(posedge clk);
            #1;
            chk("busy", j, busy, tbl[j].busy);
            chk("done", j, done, tbl[j].done);
            chk("pe_en", j, pe_en, tbl[j].pe);
            chk("lane_valid", j, lane_valid, tbl[j].lane);
            chk("res_valid", j, res_valid, tbl[j].rv);
            if (tbl[j].cc) begin
                chk("feed_cnt", j, feed_cnt, tbl[j].cnt);
                chk("res_row", j, res_row, tbl[j].row);
            end
        end
        start = 1'b0; hold = 1'b0;

        // k=255: feed_cnt runs to 257 without wrapping, done at cycle 263
        dc = 0; da = -1; mx = 0; last3 = -1;
        start = 1'b1; k_len = 8'd255;
        for (int c = 1; c <= 270; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin dc++; da = c; end
            if (int'(feed_cnt) > mx) mx = int'(feed_cnt);
            if (lane_valid[3]) last3 = int'(feed_cnt);
            if (c == 258) begin
                chk("k255_feed_cnt", c, feed_cnt, 257);
                chk("k255_lane", c, lane_valid, 4'b1000);
            end
        end
        chk("k255_done_cycle", 0, da, 263);
        chk("k255_done_count", 0, dc, 1);
        chk("k255_max_feed", 0, mx, 257);
        chk("k255_last_lane3", 0, last3, 257);

        // Reset in cycle 4 of a job aborts it asynchronously
        start = 1'b1; k_len = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 0, busy, 0);
        chk("abort_pe_en", 0, pe_en, 0);
        chk("abort_lane", 0, lane_valid, 0);
        chk("abort_feed_cnt", 0, feed_cnt, 0);
        chk("abort_res", 0, {res_valid, res_row, done}, 0);
        dc = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dc++;
        end
        chk("abort_no_done", 0, dc, 0);
        reset_n = 1'b1;
        start = 1'b1; k_len = 8'd3;
        dc = 0; da = -1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin dc++; da = c; end
            if (c == 1) chk("post_rst_busy", c, busy, 1);
        end
        chk("post_rst_done_cycle", 0, da, 11);
        chk("post_rst_done_count", 0, dc, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
